// File: rtl/ai_mac_lane_array_if.sv
// rtl/ai_mac_lane_array_if.sv - job control, input beat and result stream bundle for the MAC lane array
interface ai_mac_lane_array_if #(
  parameter int LANES  = 8,
  parameter int DATA_W = 8,
  parameter int K_MAX  = 8,
  parameter int K_W    = $clog2(K_MAX + 1)
);
  logic                    start;
  logic                    abort;
  logic [K_W-1:0]          cfg_k;
  logic [1:0]              cfg_act;
  logic [LANES*DATA_W-1:0] bias;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_act;
  logic [LANES*DATA_W-1:0] in_wt;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    out_sat;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [K_W-1:0]          beat_cnt;

  modport master (
    output start, abort, cfg_k, cfg_act, bias, in_valid, in_act, in_wt, out_ready,
    input  in_ready, out_valid, out_data, out_sat, busy, done, err, beat_cnt
  );

  modport slave (
    input  start, abort, cfg_k, cfg_act, bias, in_valid, in_act, in_wt, out_ready,
    output in_ready, out_valid, out_data, out_sat, busy, done, err, beat_cnt
  );
endinterface

// File: rtl/ai_mac_lane_array.sv
// rtl/ai_mac_lane_array.sv - LANES-wide signed MAC array with bias, selectable activation and saturation
module ai_mac_lane_array #(
  parameter int LANES  = 8,
  parameter int DATA_W = 8,
  parameter int K_MAX  = 8,
  parameter int ACC_W  = 24,
  parameter int K_W    = $clog2(K_MAX + 1)
) (
  input logic                clk,
  input logic                n_rst,
  ai_mac_lane_array_if.slave bus
);

  if (ACC_W < 2*DATA_W + $clog2(K_MAX) + 1) begin : g_acc_w_check
    $error("ai_mac_lane_array: ACC_W too narrow for DATA_W and K_MAX");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [1:0]                  state_q, state_d;
  logic signed [ACC_W-1:0]     acc_q [LANES];
  logic signed [ACC_W-1:0]     acc_d [LANES];
  logic [K_W-1:0]              k_q, k_d;
  logic [K_W-1:0]              beat_cnt_q, beat_cnt_d;
  logic [1:0]                  act_q, act_d;
  logic [LANES*DATA_W-1:0]     bias_q, bias_d;
  logic [LANES*DATA_W-1:0]     out_data_q, out_data_d;
  logic                        out_sat_q, out_sat_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic signed [2*DATA_W-1:0]  prod [LANES];
  logic [DATA_W:0]             lane_res [LANES];
  logic [LANES*DATA_W-1:0]     post_data;
  logic [LANES-1:0]            post_clip;
  logic                        k_ok;

  // Returns {clip, result} for one lane: bias add, activation, then clip to DATA_W.
  function automatic logic [DATA_W:0] post_lane(input logic signed [ACC_W-1:0] acc,
                                                input logic [DATA_W-1:0]        b,
                                                input logic [1:0]               mode);
    logic signed [ACC_W-1:0] s;
    logic [DATA_W-1:0]       r;
    logic                    clip;
    s = acc + {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
    if (s[ACC_W-1]) begin
      if (mode == 2'b01)      s = '0;
      else if (mode == 2'b10) s = s >>> 3;
    end
    r    = s[DATA_W-1:0];
    clip = 1'b0;
    if (s > SAT_MAX) begin
      r    = SAT_MAX[DATA_W-1:0];
      clip = 1'b1;
    end else if (s < SAT_MIN) begin
      r    = SAT_MIN[DATA_W-1:0];
      clip = 1'b1;
    end
    return {clip, r};
  endfunction

  assign k_ok = (bus.cfg_k != '0) && (bus.cfg_k <= K_W'(K_MAX));

  always_comb begin
    post_data = '0;
    post_clip = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i]     = $signed(bus.in_act) * $signed(bus.in_wt[i*DATA_W +: DATA_W]);
      lane_res[i] = post_lane(acc_q[i], bias_q[i*DATA_W +: DATA_W], act_q);
      post_data[i*DATA_W +: DATA_W] = lane_res[i][DATA_W-1:0];
      post_clip[i]                  = lane_res[i][DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    act_d      = act_q;
    bias_d     = bias_q;
    beat_cnt_d = beat_cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    for (int i = 0; i < LANES; i++) acc_d[i] = acc_q[i];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (k_ok) begin
            k_d        = bus.cfg_k;
            act_d      = bus.cfg_act;
            bias_d     = bus.bias;
            beat_cnt_d = '0;
            for (int i = 0; i < LANES; i++) acc_d[i] = '0;
            state_d    = S_ACCUM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        err_d = bus.start;
        if (bus.in_valid) begin
          for (int i = 0; i < LANES; i++)
            acc_d[i] = acc_q[i] + {{(ACC_W-2*DATA_W){prod[i][2*DATA_W-1]}}, prod[i]};
          beat_cnt_d = beat_cnt_q + K_W'(1);
          if (beat_cnt_d == k_q) state_d = S_POST;
        end
      end
      S_POST: begin
        err_d      = bus.start;
        out_data_d = post_data;
        out_sat_d  = |post_clip;
        state_d    = S_OUT;
      end
      S_OUT: begin
        err_d = bus.start;
        if (bus.out_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything this cycle, including a coincident start or handshake.
    if (bus.abort) begin
      state_d    = S_IDLE;
      beat_cnt_d = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      act_q      <= '0;
      bias_q     <= '0;
      beat_cnt_q <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      act_q      <= act_d;
      bias_q     <= bias_d;
      beat_cnt_q <= beat_cnt_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      done_q     <= done_d;
      err_q      <= err_d;
      for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_ai_mac_lane_array.sv
// tb/tb_ai_mac_lane_array.sv - scoreboard bench for ai_mac_lane_array
module tb_ai_mac_lane_array;
  localparam int LANES  = 8;
  localparam int DATA_W = 8;
  localparam int K_MAX  = 8;
  localparam int ACC_W  = 24;
  localparam int K_W    = 4;

  typedef struct { logic [63:0] data; logic sat; } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  ai_mac_lane_array_if #(.LANES(LANES), .DATA_W(DATA_W), .K_MAX(K_MAX), .K_W(K_W)) bus_if();

  ai_mac_lane_array #(.LANES(LANES), .DATA_W(DATA_W), .K_MAX(K_MAX), .ACC_W(ACC_W), .K_W(K_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus_if)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [7:0]  acts [8];
  logic [63:0] wts [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] w);
    for (int b = 0; b < 8; b++) begin
      acts[b] = a;
      wts[b]  = {8{w}};
    end
  endtask

  // Reference: integer sum, floor division for leaky, clamp to int8.
  function automatic exp_t model(input int k, input logic [1:0] mode, input logic [63:0] bv);
    exp_t e;
    int   s;
    e.data = '0;
    e.sat  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      s = 0;
      for (int b = 0; b < k; b++) s += $signed(acts[b]) * $signed(wts[b][l*8 +: 8]);
      s += $signed(bv[l*8 +: 8]);
      if (mode == 2'b01 && s < 0) s = 0;
      else if (mode == 2'b10 && s < 0) s = (s - 7) / 8;
      if (s > 127) begin s = 127; e.sat = 1'b1; end
      else if (s < -128) begin s = -128; e.sat = 1'b1; end
      e.data[l*8 +: 8] = 8'(s);
    end
    return e;
  endfunction

  task automatic do_start(input int k, input logic [1:0] mode, input logic [63:0] bv);
    bus_if.start   = 1'b1;
    bus_if.cfg_k   = K_W'(k);
    bus_if.cfg_act = mode;
    bus_if.bias    = bv;
    tick();
    bus_if.start = 1'b0;
    n_cmp++;
    if (bus_if.busy !== 1'b1 || bus_if.beat_cnt !== '0) begin
      n_fail++;
      $display("FAIL start_accept: busy=%b beat_cnt=%0d, want busy=1 beat_cnt=0", bus_if.busy, bus_if.beat_cnt);
    end
  endtask

  task automatic feed(input int k, input bit gap);
    int guard;
    for (int b = 0; b < k; b++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_act   = acts[b];
      bus_if.in_wt    = wts[b];
      guard = 0;
      while (bus_if.in_ready !== 1'b1 && guard < 20) begin
        tick();
        guard++;
      end
      n_cmp++;
      if (guard >= 20) begin
        n_fail++;
        $display("FAIL in_ready_timeout: beat %0d never accepted, want in_ready=1", b);
        bus_if.in_valid = 1'b0;
        return;
      end
      tick();
      bus_if.in_valid = 1'b0;
      n_cmp++;
      if (bus_if.beat_cnt !== K_W'(b + 1)) begin
        n_fail++;
        $display("FAIL beat_cnt: got %0d, want %0d", bus_if.beat_cnt, b + 1);
      end
      if (gap && b != k - 1) begin
        tick();
        n_cmp++;
        if (bus_if.beat_cnt !== K_W'(b + 1)) begin
          n_fail++;
          $display("FAIL beat_cnt_gap: got %0d, want %0d", bus_if.beat_cnt, b + 1);
        end
      end
    end
  endtask

  // Entered 1 time unit after the edge that accepted the final beat.
  task automatic collect(input int hold, input bit poke_start);
    exp_t        e;
    logic [63:0] held;
    int          guard;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (bus_if.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: out_valid=%b in POST, want 0", bus_if.out_valid);
    end
    tick();
    n_cmp++;
    if (bus_if.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: out_valid=%b two cycles after last beat, want 1", bus_if.out_valid);
      guard = 0;
      while (bus_if.out_valid !== 1'b1 && guard < 20) begin
        tick();
        guard++;
      end
      if (guard >= 20) begin
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        return;
      end
    end
    n_cmp++;
    if (bus_if.out_data !== e.data || bus_if.out_sat !== e.sat) begin
      n_fail++;
      $display("FAIL result: got data=%h sat=%b, want data=%h sat=%b", bus_if.out_data, bus_if.out_sat, e.data, e.sat);
    end
    held = bus_if.out_data;
    for (int h = 0; h < hold; h++) begin
      if (poke_start && h == 1) begin
        bus_if.start = 1'b1;
        bus_if.cfg_k = K_W'(3);
      end
      tick();
      if (poke_start && h == 1) begin
        bus_if.start = 1'b0;
        n_cmp++;
        if (bus_if.err !== 1'b1) begin
          n_fail++;
          $display("FAIL err_busy_start: err=%b, want 1", bus_if.err);
        end
      end
      n_cmp++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== held || bus_if.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold: valid=%b data=%h in_ready=%b, want valid=1 data=%h in_ready=0",
                 bus_if.out_valid, bus_if.out_data, bus_if.in_ready, held);
      end
    end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    n_cmp++;
    if (bus_if.done !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake: done=%b out_valid=%b busy=%b, want 1 0 0", bus_if.done, bus_if.out_valid, bus_if.busy);
    end
    tick();
    n_cmp++;
    if (bus_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: done=%b, want 0", bus_if.done);
    end
  endtask

  task automatic run_job(input int k, input logic [1:0] mode, input logic [63:0] bv,
                         input bit gap, input logic [63:0] xd, input logic xs);
    exp_t e;
    e.data = xd;
    e.sat  = xs;
    sb.push_back(e);
    do_start(k, mode, bv);
    feed(k, gap);
    collect(0, 1'b0);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({bus_if.in_ready, bus_if.out_valid, bus_if.out_sat, bus_if.busy, bus_if.done, bus_if.err} !== 6'b0 ||
        bus_if.out_data !== '0 || bus_if.beat_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b vld=%b sat=%b busy=%b done=%b err=%b data=%h cnt=%0d, want all 0",
               bus_if.in_ready, bus_if.out_valid, bus_if.out_sat, bus_if.busy, bus_if.done, bus_if.err,
               bus_if.out_data, bus_if.beat_cnt);
    end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    fill(8'h01, 8'h01);
    run_job(8, 2'b01, {8{8'h01}}, 1'b0, {8{8'h09}}, 1'b0);
  endtask

  task automatic test_saturation();
    fill(8'h7F, 8'h7F);
    run_job(8, 2'b00, {8{8'h7F}}, 1'b0, {8{8'h7F}}, 1'b1);
    fill(8'h7F, 8'h80);
    run_job(8, 2'b00, {8{8'h7F}}, 1'b0, {8{8'h80}}, 1'b1);
  endtask

  task automatic test_act_modes();
    fill(8'h01, 8'hFF);
    run_job(8, 2'b00, '0, 1'b0, {8{8'hF8}}, 1'b0);
    run_job(8, 2'b01, '0, 1'b0, {8{8'h00}}, 1'b0);
    run_job(8, 2'b10, '0, 1'b0, {8{8'hFF}}, 1'b0);
  endtask

  task automatic test_backpressure();
    exp_t e;
    fill(8'h01, 8'h01);
    e.data = {8{8'h09}};
    e.sat  = 1'b0;
    sb.push_back(e);
    do_start(8, 2'b01, {8{8'h01}});
    feed(8, 1'b0);
    collect(5, 1'b1);
    for (int i = 0; i < 2; i++) begin
      bus_if.start = 1'b1;
      bus_if.cfg_k = (i == 0) ? K_W'(0) : K_W'(9);
      tick();
      bus_if.start = 1'b0;
      n_cmp++;
      if (bus_if.err !== 1'b1 || bus_if.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_cfg_k: k=%0d err=%b busy=%b, want err=1 busy=0", bus_if.cfg_k, bus_if.err, bus_if.busy);
      end
      tick();
    end
  endtask

  task automatic test_gapped();
    fill(8'h01, 8'h01);
    run_job(8, 2'b01, {8{8'h01}}, 1'b1, {8{8'h09}}, 1'b0);
  endtask

  task automatic test_abort();
    fill(8'h01, 8'h01);
    do_start(8, 2'b01, {8{8'h01}});
    feed(3, 1'b0);
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.in_ready !== 1'b0 || bus_if.beat_cnt !== '0 || bus_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: busy=%b in_ready=%b cnt=%0d done=%b, want 0 0 0 0",
               bus_if.busy, bus_if.in_ready, bus_if.beat_cnt, bus_if.done);
    end
    tick();
    n_cmp++;
    if (bus_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: done=%b, want 0", bus_if.done);
    end
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    bus_if.cfg_k = K_W'(8);
    tick();
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_vs_start: busy=%b err=%b, want 0 0", bus_if.busy, bus_if.err);
    end
    run_job(8, 2'b01, {8{8'h01}}, 1'b0, {8{8'h09}}, 1'b0);
  endtask

  task automatic test_reset_in_out();
    fill(8'h01, 8'h01);
    do_start(8, 2'b01, {8{8'h01}});
    feed(8, 1'b0);
    tick();
    n_cmp++;
    if (bus_if.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_out: out_valid=%b, want 1", bus_if.out_valid);
    end
    n_rst = 1'b0;
    tick();
    n_cmp++;
    if ({bus_if.in_ready, bus_if.out_valid, bus_if.out_sat, bus_if.busy, bus_if.done, bus_if.err} !== 6'b0 ||
        bus_if.out_data !== '0 || bus_if.beat_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_in_out: vld=%b busy=%b done=%b data=%h cnt=%0d, want all 0",
               bus_if.out_valid, bus_if.busy, bus_if.done, bus_if.out_data, bus_if.beat_cnt);
    end
    n_rst = 1'b1;
    tick();
    n_cmp++;
    if (bus_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: done=%b, want 0", bus_if.done);
    end
  endtask

  task automatic test_back_to_back();
    int          k;
    logic [1:0]  mode;
    logic [63:0] bv;
    exp_t        e;
    for (int j = 0; j < 6; j++) begin
      k    = $urandom_range(1, K_MAX);
      mode = 2'($urandom_range(0, 3));
      bv   = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) begin
        acts[b] = 8'($urandom);
        wts[b]  = {$urandom, $urandom};
      end
      e = model(k, mode, bv);
      run_job(k, mode, bv, 1'($urandom_range(0, 1)), e.data, e.sat);
    end
  endtask

  initial begin
    bus_if.start     = 1'b0;
    bus_if.abort     = 1'b0;
    bus_if.cfg_k     = '0;
    bus_if.cfg_act   = '0;
    bus_if.bias      = '0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_act    = '0;
    bus_if.in_wt     = '0;
    bus_if.out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_saturation();
    test_act_modes();
    test_backpressure();
    test_gapped();
    test_abort();
    test_reset_in_out();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, want completion");
    $fatal(1, "watchdog");
  end
endmodule
